// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, load/store and shared-memory handshake
// signals of the memory arbiter.
//   ifu_*  : fetch read port (req/addr in, rdata/ack out of the arbiter)
//   lsu_*  : load/store port (req/we/addr/wdata in, rdata/ack out)
//   err    : timeout flag, pulses with the ack of an aborted access
//   mem_*  : shared memory port (req/we/addr/wdata out, rdata/ack in)
// Modport slave is the arbiter's view; master is the surrounding system.
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

interface mem_arbiter_if #(
   parameter int unsigned ISA_WIDTH = `ISA_WIDTH
);
   logic                 ifu_req;
   logic [ISA_WIDTH-1:0] ifu_addr;
   logic [ISA_WIDTH-1:0] ifu_rdata;
   logic                 ifu_ack;

   logic                 lsu_req;
   logic                 lsu_we;
   logic [ISA_WIDTH-1:0] lsu_addr;
   logic [ISA_WIDTH-1:0] lsu_wdata;
   logic [ISA_WIDTH-1:0] lsu_rdata;
   logic                 lsu_ack;

   logic                 err;

   logic                 mem_req;
   logic                 mem_we;
   logic [ISA_WIDTH-1:0] mem_addr;
   logic [ISA_WIDTH-1:0] mem_wdata;
   logic [ISA_WIDTH-1:0] mem_rdata;
   logic                 mem_ack;

   modport slave (
      input  ifu_req, ifu_addr,
      output ifu_rdata, ifu_ack,
      input  lsu_req, lsu_we, lsu_addr, lsu_wdata,
      output lsu_rdata, lsu_ack,
      output err,
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport master (
      output ifu_req, ifu_addr,
      input  ifu_rdata, ifu_ack,
      output lsu_req, lsu_we, lsu_addr, lsu_wdata,
      input  lsu_rdata, lsu_ack,
      input  err,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the fetch unit (read only)
// and the load/store unit. One access is outstanding at a time; when both
// sides request in the same idle cycle the one not granted last wins (LSU
// first after reset). An access that sees no mem_ack for TIMEOUT cycles is
// aborted and acked with err=1 and zero data.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mem_arbiter_if.slave (fetch, load/store, err and memory signals)
`ifndef ISA_WIDTH
`define ISA_WIDTH 32
`endif

module mem_arbiter #(
   parameter int unsigned ISA_WIDTH = `ISA_WIDTH,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GNT_IFU, GNT_LSU} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t               state, state_nx;
   logic                 last_lsu, last_lsu_nx;
   logic [15:0]          cnt, cnt_nx;
   logic                 mem_req_q, mem_req_nx;
   logic                 mem_we_q, mem_we_nx;
   logic [ISA_WIDTH-1:0] mem_addr_q, mem_addr_nx;
   logic [ISA_WIDTH-1:0] mem_wdata_q, mem_wdata_nx;
   logic                 ifu_ack_q, ifu_ack_nx;
   logic                 lsu_ack_q, lsu_ack_nx;
   logic                 err_q, err_nx;
   logic [ISA_WIDTH-1:0] ifu_rdata_q, ifu_rdata_nx;
   logic [ISA_WIDTH-1:0] lsu_rdata_q, lsu_rdata_nx;

   logic                 ifu_elig, lsu_elig;
   logic                 done;
   logic [ISA_WIDTH-1:0] done_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_lsu    <= 1'b0;
         cnt         <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         ifu_ack_q   <= 1'b0;
         lsu_ack_q   <= 1'b0;
         err_q       <= 1'b0;
         ifu_rdata_q <= '0;
         lsu_rdata_q <= '0;
      end else begin
         state       <= state_nx;
         last_lsu    <= last_lsu_nx;
         cnt         <= cnt_nx;
         mem_req_q   <= mem_req_nx;
         mem_we_q    <= mem_we_nx;
         mem_addr_q  <= mem_addr_nx;
         mem_wdata_q <= mem_wdata_nx;
         ifu_ack_q   <= ifu_ack_nx;
         lsu_ack_q   <= lsu_ack_nx;
         err_q       <= err_nx;
         ifu_rdata_q <= ifu_rdata_nx;
         lsu_rdata_q <= lsu_rdata_nx;
      end
   end

   // A requester whose ack is high this cycle still shows its old request
   // level; masking it prevents a duplicate grant for the same access.
   assign ifu_elig = bus.ifu_req && !ifu_ack_q;
   assign lsu_elig = bus.lsu_req && !lsu_ack_q;

   always_comb begin
      state_nx     = state;
      last_lsu_nx  = last_lsu;
      cnt_nx       = cnt;
      mem_req_nx   = mem_req_q;
      mem_we_nx    = mem_we_q;
      mem_addr_nx  = mem_addr_q;
      mem_wdata_nx = mem_wdata_q;
      ifu_ack_nx   = 1'b0;
      lsu_ack_nx   = 1'b0;
      err_nx       = 1'b0;
      ifu_rdata_nx = ifu_rdata_q;
      lsu_rdata_nx = lsu_rdata_q;
      done         = 1'b0;
      done_data    = '0;

      case (state)
         IDLE: begin
            if (lsu_elig && (!ifu_elig || !last_lsu)) begin
               state_nx     = GNT_LSU;
               last_lsu_nx  = 1'b1;
               cnt_nx       = '0;
               mem_req_nx   = 1'b1;
               mem_we_nx    = bus.lsu_we;
               mem_addr_nx  = bus.lsu_addr;
               mem_wdata_nx = bus.lsu_wdata;
            end else if (ifu_elig) begin
               state_nx     = GNT_IFU;
               last_lsu_nx  = 1'b0;
               cnt_nx       = '0;
               mem_req_nx   = 1'b1;
               mem_we_nx    = 1'b0;
               mem_addr_nx  = bus.ifu_addr;
               mem_wdata_nx = '0;
            end
         end
         GNT_IFU, GNT_LSU: begin
            // A late mem_ack in the final cycle still completes normally.
            if (bus.mem_ack) begin
               done      = 1'b1;
               done_data = mem_we_q ? '0 : bus.mem_rdata;
            end else if (cnt == CNT_LAST) begin
               done   = 1'b1;
               err_nx = 1'b1;
            end else begin
               cnt_nx = cnt + 16'd1;
            end
            if (done) begin
               state_nx   = IDLE;
               mem_req_nx = 1'b0;
               if (state == GNT_IFU) begin
                  ifu_ack_nx   = 1'b1;
                  ifu_rdata_nx = done_data;
               end else begin
                  lsu_ack_nx   = 1'b1;
                  lsu_rdata_nx = done_data;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.ifu_ack   = ifu_ack_q;
   assign bus.lsu_ack   = lsu_ack_q;
   assign bus.err       = err_q;
   assign bus.ifu_rdata = ifu_rdata_q;
   assign bus.lsu_rdata = lsu_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations followed by a
// randomized run; a transaction-level model checks every cycle at negedge.
module tb_mem_arbiter;
   localparam int unsigned TB_TIMEOUT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   mem_arbiter_if #(.ISA_WIDTH(32)) bus ();

   mem_arbiter #(.ISA_WIDTH(32), .TIMEOUT(TB_TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   task automatic chk1(input string name, input logic got, input logic exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b", name, got, exp);
   endtask

   task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // ---------------- reference model (transaction level) ----------------
   typedef enum {O_NONE, O_IFU, O_LSU} owner_t;
   owner_t      m_owner = O_NONE;
   bit          m_last_lsu = 1'b0;
   int unsigned m_age = 0;
   logic        m_we;
   logic [31:0] m_addr, m_wdata;
   bit          have_pred = 1'b0;
   logic        e_mem_req, e_ifu_ack, e_lsu_ack, e_err;
   logic [31:0] e_ifu_rdata, e_lsu_rdata;
   logic        elig_i, elig_l, n_ifu_ack, n_lsu_ack, n_err;
   logic [31:0] n_ifu_rdata, n_lsu_rdata, fin_data;

   always @(negedge clk) begin
      if (rst) begin
         chk1("rst_mem_req", bus.mem_req, 1'b0);
         chk1("rst_mem_we", bus.mem_we, 1'b0);
         chk32("rst_mem_addr", bus.mem_addr, 32'h0);
         chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
         chk1("rst_ifu_ack", bus.ifu_ack, 1'b0);
         chk1("rst_lsu_ack", bus.lsu_ack, 1'b0);
         chk1("rst_err", bus.err, 1'b0);
         chk32("rst_ifu_rdata", bus.ifu_rdata, 32'h0);
         chk32("rst_lsu_rdata", bus.lsu_rdata, 32'h0);
         m_owner = O_NONE;
         m_last_lsu = 1'b0;
         e_mem_req = 1'b0; e_ifu_ack = 1'b0; e_lsu_ack = 1'b0; e_err = 1'b0;
         e_ifu_rdata = 32'h0; e_lsu_rdata = 32'h0;
         have_pred = 1'b1;
      end else if (have_pred) begin
         chk1("mem_req", bus.mem_req, e_mem_req);
         if (e_mem_req) begin
            chk1("mem_we", bus.mem_we, m_we);
            chk32("mem_addr", bus.mem_addr, m_addr);
            chk32("mem_wdata", bus.mem_wdata, m_wdata);
         end
         chk1("ifu_ack", bus.ifu_ack, e_ifu_ack);
         chk1("lsu_ack", bus.lsu_ack, e_lsu_ack);
         chk1("err", bus.err, e_err);
         if (e_ifu_ack) chk32("ifu_rdata", bus.ifu_rdata, e_ifu_rdata);
         if (e_lsu_ack) chk32("lsu_rdata", bus.lsu_rdata, e_lsu_rdata);
      end

      // Predict the outputs after the next rising edge from current inputs.
      if (have_pred) begin
         n_ifu_ack = 1'b0; n_lsu_ack = 1'b0; n_err = 1'b0;
         n_ifu_rdata = e_ifu_rdata; n_lsu_rdata = e_lsu_rdata;
         if (m_owner == O_NONE) begin
            elig_i = bus.ifu_req && !e_ifu_ack;
            elig_l = bus.lsu_req && !e_lsu_ack;
            if (elig_l && (!elig_i || !m_last_lsu)) begin
               m_owner = O_LSU; m_last_lsu = 1'b1; m_age = 0;
               m_we = bus.lsu_we; m_addr = bus.lsu_addr; m_wdata = bus.lsu_wdata;
            end else if (elig_i) begin
               m_owner = O_IFU; m_last_lsu = 1'b0; m_age = 0;
               m_we = 1'b0; m_addr = bus.ifu_addr; m_wdata = 32'h0;
            end
         end else begin
            m_age++;
            if (bus.mem_ack || m_age == TB_TIMEOUT) begin
               fin_data = (bus.mem_ack && !m_we) ? bus.mem_rdata : 32'h0;
               n_err = !bus.mem_ack;
               if (m_owner == O_IFU) begin
                  n_ifu_ack = 1'b1; n_ifu_rdata = fin_data;
               end else begin
                  n_lsu_ack = 1'b1; n_lsu_rdata = fin_data;
               end
               m_owner = O_NONE;
            end
         end
         e_mem_req = (m_owner != O_NONE);
         e_ifu_ack = n_ifu_ack; e_lsu_ack = n_lsu_ack; e_err = n_err;
         e_ifu_rdata = n_ifu_rdata; e_lsu_rdata = n_lsu_rdata;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      bus.ifu_req = 1'b0; bus.ifu_addr = 32'h0;
      bus.lsu_req = 1'b0; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h0; bus.lsu_wdata = 32'h0;
      bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      zero_inputs();
      repeat (2) tick();
      @(negedge clk);
      #1 rst = 1'b0;
      tick();
   endtask

   task automatic run_random(input int unsigned n);
      for (int unsigned c = 0; c < n; c++) begin
         tick();
         if (bus.ifu_req && bus.ifu_ack) begin
            if ($urandom_range(3) == 0) bus.ifu_addr = $urandom;
            else bus.ifu_req = 1'b0;
         end else if (!bus.ifu_req && $urandom_range(2) == 0) begin
            bus.ifu_req = 1'b1; bus.ifu_addr = $urandom;
         end else if (bus.ifu_req && bus.mem_req && $urandom_range(19) == 0) begin
            bus.ifu_req = 1'b0;
         end
         if (bus.lsu_req && bus.lsu_ack) begin
            if ($urandom_range(3) == 0) begin
               bus.lsu_we = 1'($urandom_range(1)); bus.lsu_addr = $urandom; bus.lsu_wdata = $urandom;
            end else bus.lsu_req = 1'b0;
         end else if (!bus.lsu_req && $urandom_range(2) == 0) begin
            bus.lsu_req = 1'b1; bus.lsu_we = 1'($urandom_range(1));
            bus.lsu_addr = $urandom; bus.lsu_wdata = $urandom;
         end
         bus.mem_rdata = $urandom;
         bus.mem_ack = bus.mem_req ? ($urandom_range(99) < 35) : ($urandom_range(9) == 0);
      end
   endtask

   int unsigned cyc;

   initial begin
      zero_inputs();
      do_reset();

      // Single fetch with minimum latency.
      bus.ifu_req = 1'b1; bus.ifu_addr = 32'h8000_0000;
      tick();
      chk1("f_mem_req", bus.mem_req, 1'b1);
      chk32("f_mem_addr", bus.mem_addr, 32'h8000_0000);
      chk1("f_mem_we", bus.mem_we, 1'b0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0413;
      tick();
      chk1("f_ifu_ack", bus.ifu_ack, 1'b1);
      chk32("f_ifu_rdata", bus.ifu_rdata, 32'h0000_0413);
      chk1("f_mem_req_drop", bus.mem_req, 1'b0);
      bus.ifu_req = 1'b0; bus.mem_ack = 1'b0;
      tick();
      chk1("f_ifu_ack_pulse", bus.ifu_ack, 1'b0);

      // Simultaneous requests after reset: LSU store first, then IFU.
      do_reset();
      bus.ifu_req = 1'b1; bus.ifu_addr = 32'h8000_0100;
      bus.lsu_req = 1'b1; bus.lsu_we = 1'b1;
      bus.lsu_addr = 32'h8000_1000; bus.lsu_wdata = 32'hDEAD_BEEF;
      tick();
      chk1("s_mem_we", bus.mem_we, 1'b1);
      chk32("s_mem_addr", bus.mem_addr, 32'h8000_1000);
      chk32("s_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
      tick();
      chk1("s_lsu_ack", bus.lsu_ack, 1'b1);
      chk32("s_lsu_rdata", bus.lsu_rdata, 32'h0);
      bus.mem_ack = 1'b0;
      tick();
      bus.lsu_req = 1'b0;
      chk1("s_ifu_grant", bus.mem_req, 1'b1);
      chk32("s_ifu_addr", bus.mem_addr, 32'h8000_0100);
      chk1("s_no_lsu_reack", bus.lsu_ack, 1'b0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0BAD_F00D;
      tick();
      chk1("s_ifu_ack", bus.ifu_ack, 1'b1);
      chk1("s_lsu_ack_quiet", bus.lsu_ack, 1'b0);
      bus.ifu_req = 1'b0; bus.mem_ack = 1'b0;
      tick();

      // Both held continuously: grants alternate LSU, IFU, ...
      do_reset();
      bus.ifu_req = 1'b1; bus.ifu_addr = 32'h0000_0100;
      bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h0000_0200;
      tick();
      for (int t = 0; t < 6; t++) begin
         chk1("rr_mem_req", bus.mem_req, 1'b1);
         chk32("rr_mem_addr", bus.mem_addr, (t % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100);
         tick();
         tick();
         bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1000 + 32'(t);
         tick();
         chk1("rr_lsu_ack", bus.lsu_ack, (t % 2 == 0));
         chk1("rr_ifu_ack", bus.ifu_ack, (t % 2 != 0));
         chk32("rr_rdata", (t % 2 == 0) ? bus.lsu_rdata : bus.ifu_rdata, 32'h1000 + 32'(t));
         bus.mem_ack = 1'b0;
         tick();
      end
      bus.ifu_req = 1'b0; bus.lsu_req = 1'b0;
      repeat (8) tick();

      // Timeout abort, then completion in the final cycle.
      do_reset();
      bus.mem_rdata = 32'hA5A5_A5A5;
      bus.lsu_req = 1'b1; bus.lsu_we = 1'b0; bus.lsu_addr = 32'h0000_0300;
      tick();
      cyc = 0;
      while (bus.mem_req && cyc < 20) begin
         cyc++;
         tick();
      end
      chk32("to_req_cycles", cyc, 32'd4);
      chk1("to_lsu_ack", bus.lsu_ack, 1'b1);
      chk1("to_err", bus.err, 1'b1);
      chk32("to_lsu_rdata", bus.lsu_rdata, 32'h0);
      bus.lsu_req = 1'b0;
      tick();
      chk1("to_err_pulse", bus.err, 1'b0);
      bus.lsu_req = 1'b1;
      repeat (4) tick();
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
      tick();
      chk1("late_lsu_ack", bus.lsu_ack, 1'b1);
      chk1("late_err", bus.err, 1'b0);
      chk32("late_rdata", bus.lsu_rdata, 32'hCAFE_F00D);
      bus.mem_ack = 1'b0; bus.lsu_req = 1'b0;
      tick();

      // Asynchronous reset in the middle of a granted fetch.
      do_reset();
      bus.ifu_req = 1'b1; bus.ifu_addr = 32'h0000_0400;
      tick();
      tick();
      chk1("ar_granted", bus.mem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("ar_req_async", bus.mem_req, 1'b0);
      chk1("ar_no_ack", bus.ifu_ack, 1'b0);
      @(negedge clk);
      #1 rst = 1'b0;
      tick();
      chk1("ar_regrant", bus.mem_req, 1'b1);
      chk32("ar_addr", bus.mem_addr, 32'h0000_0400);
      bus.mem_ack = 1'b1; bus.mem_rdata = 32'h0000_0055;
      tick();
      chk1("ar_ifu_ack", bus.ifu_ack, 1'b1);
      chk32("ar_ifu_rdata", bus.ifu_rdata, 32'h0000_0055);
      bus.mem_ack = 1'b0; bus.ifu_req = 1'b0;
      tick();

      // Randomized traffic checked by the model.
      do_reset();
      run_random(4000);
      zero_inputs();
      repeat (10) tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ISA_WIDTH, default `ISA_WIDTH (32), address and data width of all ports.
REQ-002 Parameter TIMEOUT, default 255, cycles without mem_ack before a granted access is aborted; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 ifu_req  input  1  fetch read request, level-held until ifu_ack.
REQ-006 ifu_addr  input  ISA_WIDTH  fetch address, stable while ifu_req=1.
REQ-007 ifu_rdata  output  ISA_WIDTH  fetch read data, valid only while ifu_ack=1.
REQ-008 ifu_ack  output  1  one-cycle completion pulse to the fetch unit.
REQ-009 lsu_req  input  1  load/store request from exu_mem, level-held until lsu_ack.
REQ-010 lsu_we  input  1  1=write, 0=read.
REQ-011 lsu_addr  input  ISA_WIDTH  data address.
REQ-012 lsu_wdata  input  ISA_WIDTH  store data.
REQ-013 lsu_rdata  output  ISA_WIDTH  load data, valid only while lsu_ack=1.
REQ-014 lsu_ack  output  1  one-cycle completion pulse to the load/store side.
REQ-015 err  output  1  one-cycle pulse coincident with the ack of a timed-out access.
REQ-016 mem_req  output  1  shared memory port request, registered.
REQ-017 mem_we  output  1  write enable, registered.
REQ-018 mem_addr  output  ISA_WIDTH  registered address.
REQ-019 mem_wdata  output  ISA_WIDTH  registered write data.
REQ-020 mem_rdata  input  ISA_WIDTH  memory read data, valid while mem_ack=1.
REQ-021 mem_ack  input  1  memory completion; sampled only while mem_req=1.

Function
REQ-022 FSM states: IDLE, GNT_IFU, GNT_LSU; one transaction outstanding at a time.
REQ-023 IDLE: eligible request = req high and own ack low in that cycle (masks the stale request during its ack cycle).
REQ-024 IDLE, single eligible requester: next state GNT_<that requester>.
REQ-025 IDLE, both eligible: round-robin; grant the requester not granted last; after reset LSU has priority.
REQ-026 On the IDLE->GNT edge: latch mem_addr and mem_we (0 for IFU); latch mem_wdata (0 for IFU); set mem_req=1; clear timeout counter.
REQ-027 mem_req, mem_we, mem_addr, mem_wdata constant throughout a GNT state.
REQ-028 GNT state, mem_ack=1 at an edge: mem_req->0, state->IDLE, granted ack=1 for exactly the next cycle, rdata registered from mem_rdata (0 for writes), err=0.
REQ-029 Minimum latency: req high in cycle 0, mem_req high in cycle 1, mem_ack high in cycle 1, ack high in cycle 2.
REQ-030 GNT state, mem_ack=0: 16-bit counter increments; at counter==TIMEOUT-1 with mem_ack=0: abort -- mem_req->0, state->IDLE, granted ack=1 and err=1 for one cycle, rdata=0.
REQ-031 mem_ack in the abort cycle takes precedence over the timeout: normal completion, err=0.
REQ-032 mem_ack while mem_req=0 is ignored.
REQ-033 A req dropped while granted (protocol violation) does not cancel the access; the ack is still produced.
REQ-034 ifu_ack and lsu_ack never high in the same cycle; never high without a prior grant.
REQ-035 rdata outputs hold their last value outside ack cycles; only ack-cycle values are defined.

Reset
REQ-036 While rst=1, asynchronously: state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ifu_ack=0, lsu_ack=0, err=0, ifu_rdata=0, lsu_rdata=0, counter=0, last-grant=IFU (LSU priority first).
REQ-037 Reset mid-transaction abandons the access without any ack; the first grant after deassertion follows REQ-025.

Verification
REQ-038 Single fetch: ifu_req=1, ifu_addr=0x80000000, mem_ack with mem_rdata=0x00000413 one cycle after mem_req -> mem_addr=0x80000000, mem_we=0, ifu_ack pulse with ifu_rdata=0x00000413, state IDLE.
REQ-039 Simultaneous ifu_req and lsu_req after reset, store lsu_addr=0x80001000, lsu_wdata=0xDEADBEEF -> LSU granted first (mem_we=1, mem_wdata=0xDEADBEEF), lsu_ack with lsu_rdata=0, then IFU granted without lsu_ack re-trigger.
REQ-040 Both requesters held continuously for 6 transactions, mem_ack 2 cycles after mem_req -> grants alternate LSU, IFU, LSU, IFU, LSU, IFU; no back-to-back duplicate ack.
REQ-041 TIMEOUT=4, lsu_req read, mem_ack never asserted -> mem_req high exactly 4 cycles, then lsu_ack=1, err=1, lsu_rdata=0; mem_ack arriving in the 4th cycle instead -> err=0, data returned.
REQ-042 rst asserted 2 cycles into a granted fetch -> mem_req=0 immediately (same cycle, asynchronous), no ifu_ack; after release with ifu_req still high -> fresh grant, normal completion.
